// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default sizes for the 2R1W register file
package reg_file_pkg;

    localparam int DEF_DATA_W = 18;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read, write and bulk-clear signal bundle for the register file
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data_a, rd_data_b, wr_ready, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
        output rd_data_a, rd_data_b, wr_ready, clr_busy, clr_done
    );

endinterface

// File: rtl/reg_file_clear_seq.sv
// rtl/reg_file_clear_seq.sv - bulk-clear sequencer walking every register once
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_busy,
    output logic              clr_done
);

    // Last register index is all ones, so the pointer stops there and never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        state;
    clr_state_t        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    // State and pointer registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic: one register cleared per CLEAR cycle, then a one-cycle DONE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nxt = DONE;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_addr = ptr;
    assign clr_busy = (state != IDLE);

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - two-read one-write register file with bypass, zero register and bulk clear
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    reg_file_if.slave bus
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_busy;
    logic              wr_fire;
    logic              wr_to_zero;

    reg_file_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_busy (clr_busy),
        .clr_done (bus.clr_done)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.wr_ready = !clr_busy;
    assign wr_fire      = bus.wr_en && !clr_busy;
    assign wr_to_zero   = ZERO_REG && (bus.wr_addr == '0);

    // Storage update: the clear sequencer wins; user writes only land when accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire && !wr_to_zero) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Port A read: storage, then same-cycle write forwarding, then zero-register override.
    always_comb begin
        bus.rd_data_a = mem[bus.rd_addr_a];
        if (BYPASS && wr_fire && (bus.wr_addr == bus.rd_addr_a)) begin
            bus.rd_data_a = bus.wr_data;
        end
        if (ZERO_REG && (bus.rd_addr_a == '0)) begin
            bus.rd_data_a = '0;
        end
    end

    // Port B read: same selection as port A.
    always_comb begin
        bus.rd_data_b = mem[bus.rd_addr_b];
        if (BYPASS && wr_fire && (bus.wr_addr == bus.rd_addr_b)) begin
            bus.rd_data_b = bus.wr_data;
        end
        if (ZERO_REG && (bus.rd_addr_b == '0)) begin
            bus.rd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - directed vector bench for reg_file_2r1w in two parameter sets
module tb_reg_file_2r1w;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(18), .ADDR_W(4)) b0 ();
    reg_file_if #(.DATA_W(18), .ADDR_W(4)) b1 ();

    reg_file_2r1w #(.DATA_W(18), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    reg_file_2r1w #(.DATA_W(18), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [17:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [17:0] a0;
        logic [17:0] b0;
        logic [17:0] a1;
        logic [17:0] b1;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [17:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb, input logic cr);
        b0.wr_en = we; b0.wr_addr = wa; b0.wr_data = wd;
        b0.rd_addr_a = ra; b0.rd_addr_b = rb; b0.clr_req = cr;
        b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd;
        b1.rd_addr_a = ra; b1.rd_addr_b = rb; b1.clr_req = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 4'(i), 18'h100 + 18'(i), 4'd0, 4'd0, 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 18'h0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic start_clear();
        drive(1'b0, 4'd0, 18'h0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 18'h0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;
        int done_cycle;
        int done_cnt;
        int guard;

        drive(1'b0, 4'd0, 18'h0, 4'd0, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);

        // Reset pulse mid-cycle: everything reads back as zero right away.
        #3 rst = 1'b1;
        #1;
        for (int r = 0; r < 16; r++) begin
            b0.rd_addr_a = 4'(r); b1.rd_addr_a = 4'(r);
            #1;
            chk($sformatf("reset_rd0_r%0d", r), b0.rd_data_a, 18'h0);
            chk($sformatf("reset_rd1_r%0d", r), b1.rd_data_a, 18'h0);
        end
        chk("reset_wr_ready", b0.wr_ready, 1'b1);
        chk("reset_clr_busy", b0.clr_busy, 1'b0);
        chk("reset_clr_done", b0.clr_done, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Per-cycle vectors: inputs for the cycle, expected reads before the edge.
        vecs[0]  = '{1'b0, 4'd0,  18'h00000, 4'd5,  4'd0, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
        vecs[1]  = '{1'b1, 4'd5,  18'h2A5F3, 4'd1,  4'd2, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
        vecs[2]  = '{1'b0, 4'd0,  18'h00000, 4'd5,  4'd5, 18'h2A5F3, 18'h2A5F3, 18'h2A5F3, 18'h2A5F3};
        vecs[3]  = '{1'b1, 4'd0,  18'h3FFFF, 4'd0,  4'd5, 18'h00000, 18'h2A5F3, 18'h00000, 18'h2A5F3};
        vecs[4]  = '{1'b0, 4'd0,  18'h00000, 4'd0,  4'd0, 18'h00000, 18'h00000, 18'h3FFFF, 18'h3FFFF};
        vecs[5]  = '{1'b1, 4'd3,  18'h00011, 4'd4,  4'd4, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
        vecs[6]  = '{1'b1, 4'd3,  18'h1ABCD, 4'd3,  4'd3, 18'h1ABCD, 18'h1ABCD, 18'h00011, 18'h00011};
        vecs[7]  = '{1'b0, 4'd0,  18'h00000, 4'd3,  4'd5, 18'h1ABCD, 18'h2A5F3, 18'h1ABCD, 18'h2A5F3};
        vecs[8]  = '{1'b1, 4'd0,  18'h12345, 4'd0,  4'd0, 18'h00000, 18'h00000, 18'h3FFFF, 18'h3FFFF};
        vecs[9]  = '{1'b1, 4'd15, 18'h3FFFF, 4'd15, 4'd0, 18'h3FFFF, 18'h00000, 18'h00000, 18'h12345};
        vecs[10] = '{1'b0, 4'd0,  18'h00000, 4'd15, 4'd3, 18'h3FFFF, 18'h1ABCD, 18'h3FFFF, 18'h1ABCD};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 1'b0);
            #1;
            chk($sformatf("vec%0d_dut0_a", i), b0.rd_data_a, vecs[i].a0);
            chk($sformatf("vec%0d_dut0_b", i), b0.rd_data_b, vecs[i].b0);
            chk($sformatf("vec%0d_dut1_a", i), b1.rd_data_a, vecs[i].a1);
            chk($sformatf("vec%0d_dut1_b", i), b1.rd_data_b, vecs[i].b1);
            chk($sformatf("vec%0d_wr_ready", i), b0.wr_ready, 1'b1);
            tick();
        end

        // Bulk clear: 16 CLEAR cycles plus DONE, pulse on the 17th busy cycle.
        fill();
        start_clear();
        busy_cycles = 0;
        done_cycle  = 0;
        done_cnt    = 0;
        for (int c = 1; c <= 25; c++) begin
            #1;
            if (b0.clr_busy) busy_cycles++;
            if (b0.clr_done) begin
                done_cnt++;
                if (done_cycle == 0) done_cycle = c;
            end
            if (c == 3) begin
                drive(1'b0, 4'd0, 18'h0, 4'd1, 4'd5, 1'b0);
                #1;
                chk("midclear_r1_cleared", b0.rd_data_a, 18'h0);
                chk("midclear_r5_old", b0.rd_data_b, 18'h105);
                chk("midclear_dut1_r5_old", b1.rd_data_b, 18'h105);
                chk("midclear_wr_ready", b0.wr_ready, 1'b0);
            end
            tick();
        end
        chk("clear_busy_cycles", busy_cycles, 17);
        chk("clear_done_cycle", done_cycle, 17);
        chk("clear_done_count", done_cnt, 1);
        for (int r = 0; r < 16; r++) begin
            drive(1'b0, 4'd0, 18'h0, 4'(r), 4'(r), 1'b0);
            #1;
            chk($sformatf("after_clear_dut0_r%0d", r), b0.rd_data_b, 18'h0);
            chk($sformatf("after_clear_dut1_r%0d", r), b1.rd_data_a, 18'h0);
        end
        tick();

        // Writes held during the tail of CLEAR and through DONE are dropped.
        start_clear();
        for (int c = 1; c <= 17; c++) begin
            if (c >= 10) drive(1'b1, 4'd7, 18'h00777, 4'd7, 4'd7, 1'b0);
            #1;
            if (c == 17) begin
                chk("drop_done_pulse", b0.clr_done, 1'b1);
                chk("drop_done_wr_ready", b0.wr_ready, 1'b0);
                chk("drop_done_no_bypass", b0.rd_data_a, 18'h0);
            end
            tick();
        end
        drive(1'b0, 4'd0, 18'h0, 4'd7, 4'd7, 1'b0);
        #1;
        chk("drop_idle_busy", b0.clr_busy, 1'b0);
        chk("drop_idle_wr_ready", b0.wr_ready, 1'b1);
        chk("drop_r7_dut0", b0.rd_data_a, 18'h0);
        chk("drop_r7_dut1", b1.rd_data_a, 18'h0);
        tick();

        // Write and clear request in the same idle cycle: write lands, then gets zeroed.
        drive(1'b1, 4'd7, 18'h00777, 4'd7, 4'd7, 1'b1);
        #1;
        chk("same_cycle_bypass_dut0", b0.rd_data_a, 18'h00777);
        chk("same_cycle_nobypass_dut1", b1.rd_data_a, 18'h0);
        tick();
        drive(1'b0, 4'd0, 18'h0, 4'd7, 4'd7, 1'b0);
        #1;
        chk("same_cycle_busy", b0.clr_busy, 1'b1);
        chk("same_cycle_r7_stored_dut0", b0.rd_data_a, 18'h00777);
        chk("same_cycle_r7_stored_dut1", b1.rd_data_a, 18'h00777);
        guard = 0;
        while (b0.clr_busy && guard < 40) begin
            tick();
            guard++;
        end
        chk("same_cycle_clear_ends", b0.clr_busy, 1'b0);
        chk("same_cycle_r7_zeroed_dut0", b0.rd_data_a, 18'h0);
        chk("same_cycle_r7_zeroed_dut1", b1.rd_data_a, 18'h0);
        tick();

        // Reset during clear cycle 6 aborts the sequence with no done pulse.
        fill();
        start_clear();
        for (int c = 1; c < 6; c++) tick();
        drive(1'b0, 4'd0, 18'h0, 4'd6, 4'd15, 1'b0);
        #1;
        chk("pre_abort_r6_old", b0.rd_data_a, 18'h106);
        chk("pre_abort_busy", b0.clr_busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        for (int r = 5; r < 16; r++) begin
            drive(1'b0, 4'd0, 18'h0, 4'(r), 4'(r), 1'b0);
            #0.1;
            chk($sformatf("abort_dut0_r%0d", r), b0.rd_data_a, 18'h0);
            chk($sformatf("abort_dut1_r%0d", r), b1.rd_data_b, 18'h0);
        end
        chk("abort_busy", b0.clr_busy, 1'b0);
        chk("abort_done", b0.clr_done, 1'b0);
        chk("abort_wr_ready", b0.wr_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        done_cnt    = 0;
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (b0.clr_done) done_cnt++;
            if (b0.clr_busy) busy_cycles++;
        end
        chk("abort_no_done_after", done_cnt, 0);
        chk("abort_stays_idle", busy_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
